clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
- Run-time controller for the fractional-free clock divider datapath. It owns the divider counter and the output toggle flop.
- Two requesters share it through a round-robin req/ack handshake; each can ask for a new half-period value.
- A granted change is applied only at a full-period boundary, so duty cycle stays 50% and no runt pulses occur.
- Sits between the system clock and the slow-clock consumers (UART/SPI/LED timing) that today use fixed-ratio dividers.

Parameters:
- W, 5, width of the half-period divisor and the internal counter.
- DEFAULT_DIV, 5'd4, divisor loaded at reset. Half-period is DEFAULT_DIV+1 cycles, so the output is clk/10.

Ports:
- clk      input   1  system clock; all logic on its rising edge.
- rst      input   1  synchronous, active-high reset.
- en       input   1  divider run enable.
- req0     input   1  requester 0 change request (level).
- div0     input   W  requester 0 requested divisor.
- ack0     output  1  one-cycle completion pulse to requester 0.
- req1     input   1  requester 1 change request (level).
- div1     input   W  requester 1 requested divisor.
- ack1     output  1  one-cycle completion pulse to requester 1.
- freqMhz  output  1  divided clock output (registered).
- cur_div  output  W  divisor currently in effect.
- busy     output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at a clk edge) sets freqMhz=0, cnt=0, cur_div=DEFAULT_DIV, ack0=ack1=0, busy=0, FSM=IDLE, rr_ptr=0 and pend=0.
- Reset overrides everything. Reset mid-operation aborts any in-flight change and issues no ack.
- Divider:
  - With en=1: if cnt==cur_div, then freqMhz toggles and cnt goes to 0; otherwise cnt increments by 1.
  - Output period is 2*(cur_div+1) cycles. cur_div=0 gives clk/2. cur_div=31 gives clk/64.
  - With en=0: cnt is held at 0 and freqMhz is held at 0.
- Boundary event: bnd = (en && cnt==cur_div && freqMhz==1), i.e. the cycle in which the output falls. When en=0, bnd=1 every cycle.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - Arbitration: with exactly one req high, that requester is granted. With both high, the requester indexed by rr_ptr is granted.
  - On a grant: latch its div into pend, record the grant id g, and set rr_ptr to the non-granted index.
  - If the latched value equals cur_div, go to ACK; otherwise go to WAIT.
  - With no req: stay in IDLE.
- WAIT:
  - Requests are ignored.
  - On bnd: cur_div<=pend in the same edge where the counter wraps to 0 and freqMhz goes to 0. Then go to ACK.
  - The first new half-period (low phase) therefore already uses pend.
- ACK: assert ack_g for exactly one cycle, then go to IDLE. busy is 1 in WAIT and ACK.
- Latency:
  - A request seen in IDLE at edge t reaches WAIT at t+1.
  - The ack is high in the cycle after the boundary edge.
  - Worst case from request to ack with en=1 is 2*(old cur_div+1)+2 cycles.
  - With en=0, or on a same-value request, the ack is high at t+2.
- Requester rules:
  - Hold req and div stable until the ack.
  - Dropping req during WAIT does not cancel the change; the ack still pulses.
  - req still high in IDLE after the ack is treated as a new request.
- Changing div while in WAIT has no effect, because pend is already latched.
- ack0 and ack1 are never high together.
- en toggling while in WAIT: as soon as en=0, bnd=1 and the change applies on that edge.

Optional Feature:
- Macro: CLK_DIV_SCHED_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - When lock=1, IDLE grants nothing and requests stay pending.
  - WAIT and ACK complete normally regardless of lock.
- When undefined: the lock port is absent and grants behave as if lock=0.

Test Plan:
- Reset: assert rst for 2 cycles, then release with en=1. Expect cur_div=4 and freqMhz with period 10 cycles (5 high, 5 low). Expect ack0=ack1=0 and busy=0.
- Single change: req0=1, div0=1 while freqMhz is mid-high-phase. Expect busy=1 next cycle and cur_div=1 at the falling edge of freqMhz. Expect ack0 one cycle later, then period 4 cycles. freqMhz must show no high or low phase shorter than 2 cycles.
- Contention:
  - req0 and req1 both high in IDLE after reset (rr_ptr=0), div0=9 and div1=24. Expect grant 0 first (ack0, cur_div=9).
  - With both still high, expect grant 1 next (ack1, cur_div=24), period 50 cycles.
- Same value and disabled divider:
  - req1 with div1 equal to cur_div gives ack1 two cycles after the request, and the divider phase is unchanged.
  - With en=0, req0 and div0=8 gives cur_div=8 and ack0 two cycles after the request, with freqMhz=0 throughout.
- Reset mid-WAIT: grant req0 with div0=1, then assert rst while in WAIT. Expect no ack0 and cur_div=4 after reset. The FSM is IDLE and freqMhz restarts from 0.
- Lock (with CLK_DIV_SCHED_LOCK_EN): lock=1 and req0=1 for 30 cycles gives no grant and busy=0. Dropping lock gives a grant the next cycle and normal completion.

Source files
------------

// File: rtl/clk_div_sched_if.sv
// Request/ack and divider-status bundle for clk_div_sched.
// The master side (requesters and slow-clock consumers) drives the run enable
// and the two change requests; the slave side (the scheduler) returns the
// acks, the divided clock, the divisor in effect and the busy flag.
interface clk_div_sched_if #(
  parameter int W = 5
);
  logic         en;
  logic         req0;
  logic [W-1:0] div0;
  logic         ack0;
  logic         req1;
  logic [W-1:0] div1;
  logic         ack1;
  logic         freqMhz;
  logic [W-1:0] cur_div;
  logic         busy;

  modport master (
    output en, req0, div0, req1, div1,
    input  ack0, ack1, freqMhz, cur_div, busy
  );

  modport slave (
    input  en, req0, div0, req1, div1,
    output ack0, ack1, freqMhz, cur_div, busy
  );
endinterface

// File: rtl/clk_div_sched.sv
// Run-time controlled 50% duty clock divider with a two-requester round-robin
// scheduler. A requested half-period value is latched on grant and applied
// only on the edge where the divided clock falls, so no runt phase is ever
// produced.
// Optional build macro: CLK_DIV_SCHED_LOCK_EN adds a 'lock' input that stops
// new grants while high (changes already in progress still complete).
module clk_div_sched #(
  parameter int           W           = 5,
  parameter logic [W-1:0] DEFAULT_DIV = 5'd4
) (
  input logic            clk,
  input logic            rst,
`ifdef CLK_DIV_SCHED_LOCK_EN
  input logic            lock,
`endif
  clk_div_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         freq_q;
  logic         freq_d;
  logic [W-1:0] curDiv_q;
  logic [W-1:0] pend_q;
  logic         rrPtr_q;
  logic         grantId_q;
  logic         ack0_q;
  logic         ack1_q;
  logic         busy_q;

  logic         bnd;
  logic         grantBlock;
  logic         anyReq;
  logic         grantSel;
  logic [W-1:0] grantDiv;
  logic         applyNow;

`ifdef CLK_DIV_SCHED_LOCK_EN
  assign grantBlock = lock;
`else
  assign grantBlock = 1'b0;
`endif

  // Divider next state: count up to the divisor, then wrap and toggle; parked low when disabled
  always_comb begin
    cnt_d  = cnt_q;
    freq_d = freq_q;
    if (!bus.en) begin
      cnt_d  = '0;
      freq_d = 1'b0;
    end else if (cnt_q == curDiv_q) begin
      cnt_d  = '0;
      freq_d = ~freq_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // The output falls on this edge (or the divider is parked), so a new divisor is safe to take
  assign bnd = !bus.en || ((cnt_q == curDiv_q) && freq_q);

  // A request equal to the running divisor needs no boundary; it leaves WAIT on its first
  // cycle without touching the counter, so its ack timing matches the disabled-divider case
  assign applyNow = bnd || (pend_q == curDiv_q);

  // Round-robin arbitration: a lone request wins, a tie goes to the requester rrPtr points at
  always_comb begin
    anyReq   = (bus.req0 || bus.req1) && !grantBlock;
    grantSel = (bus.req0 && bus.req1) ? rrPtr_q : bus.req1;
    grantDiv = grantSel ? bus.div1 : bus.div0;
  end

  // Divider counter and output toggle flop
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      freq_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      freq_q <= freq_d;
    end
  end

  // Scheduler FSM: grant in IDLE, hold the change in WAIT until a boundary, pulse the ack in ACK
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      curDiv_q  <= DEFAULT_DIV;
      pend_q    <= '0;
      rrPtr_q   <= 1'b0;
      grantId_q <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (anyReq) begin
            pend_q    <= grantDiv;
            grantId_q <= grantSel;
            rrPtr_q   <= ~grantSel;
            busy_q    <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (applyNow) begin
            curDiv_q <= pend_q;
            ack0_q   <= ~grantId_q;
            ack1_q   <= grantId_q;
            state_q  <= S_ACK;
          end
        end
        S_ACK: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.freqMhz = freq_q;
  assign bus.cur_div = curDiv_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched. Expected behaviour is derived from
// the divider rules directly: phase lengths of divisor+1 cycles, ack latency
// bounds, and the divisor value each request should leave in effect.
module tb_clk_div_sched;

  logic clk;
  logic rst;
`ifdef CLK_DIV_SCHED_LOCK_EN
  logic lock;
`endif

  int errors;
  int checks;
  int expDiv;

  clk_div_sched_if #(.W(5)) bus ();

  clk_div_sched #(
    .W(5),
    .DEFAULT_DIV(5'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef CLK_DIV_SCHED_LOCK_EN
    .lock(lock),
`endif
    .bus(bus)
  );

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hang guard
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.en = 1'b1;
    expDiv = 4;
  endtask

  // Waits (at least one edge) for either ack, bounded by limit edges
  task automatic waitAck(input int limit, output int n, output logic a0, output logic a1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.ack0 || bus.ack1) && n < limit);
    a0 = bus.ack0;
    a1 = bus.ack1;
  endtask

  // Measures lengths of complete freqMhz phases over a window (partial first/last runs excluded)
  task automatic measureRuns(input int ncycles, output int minRun, output int maxRun, output int fullRuns);
    logic prev;
    int   run;
    bit   first;
    prev = bus.freqMhz;
    run = 1;
    first = 1'b1;
    minRun = 1000;
    maxRun = 0;
    fullRuns = 0;
    for (int i = 0; i < ncycles; i++) begin
      tick();
      if (bus.freqMhz === prev) begin
        run++;
      end else begin
        if (!first) begin
          if (run < minRun) minRun = run;
          if (run > maxRun) maxRun = run;
          fullRuns++;
        end
        first = 1'b0;
        prev = bus.freqMhz;
        run = 1;
      end
    end
  endtask

  // Waits for the sample right after freqMhz falls
  task automatic alignFall(input int limit, output int n);
    logic prev;
    n = 0;
    prev = bus.freqMhz;
    tick();
    n++;
    while (!(prev === 1'b1 && bus.freqMhz === 1'b0) && n < limit) begin
      prev = bus.freqMhz;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    int mn, mx, fr;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.div0 = '0;
    bus.div1 = '0;
    tick();
    tick();
    checks++;
    if (bus.cur_div !== 5'd4) begin errors++; $display("[TB] FAIL reset_cur_div got=%0d want=4", bus.cur_div); end
    checks++;
    if (bus.freqMhz !== 1'b0) begin errors++; $display("[TB] FAIL reset_freq got=%b want=0", bus.freqMhz); end
    checks++;
    if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_acks got=%b%b want=00", bus.ack0, bus.ack1); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
    rst = 1'b0;
    bus.en = 1'b1;
    expDiv = 4;
    n = 0;
    while (bus.freqMhz !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (n != 5) begin errors++; $display("[TB] FAIL reset_first_rise got=%0d want=5", n); end
    measureRuns(40, mn, mx, fr);
    checks++;
    if (mn != 5 || mx != 5 || fr < 2) begin
      errors++; $display("[TB] FAIL reset_period got=min%0d/max%0d/runs%0d want=5/5/>=2", mn, mx, fr);
    end
  endtask

  task automatic test_single_change();
    int   n;
    int   mn, mx, fr;
    logic prevF;
    n = 0;
    while (bus.freqMhz !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    tick();
    bus.req0 = 1'b1;
    bus.div0 = 5'd1;
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.ack0 !== 1'b0) begin
      errors++; $display("[TB] FAIL single_busy got=busy%b/ack%b want=1/0", bus.busy, bus.ack0);
    end
    n = 1;
    prevF = bus.freqMhz;
    while (!(bus.ack0 || bus.ack1) && n < 13) begin
      prevF = bus.freqMhz;
      tick();
      n++;
    end
    checks++;
    if (bus.ack0 !== 1'b1 || bus.ack1 !== 1'b0) begin
      errors++; $display("[TB] FAIL single_ack got=%b%b want=10", bus.ack0, bus.ack1);
    end
    checks++;
    if (bus.cur_div !== 5'd1) begin errors++; $display("[TB] FAIL single_cur_div got=%0d want=1", bus.cur_div); end
    checks++;
    if (prevF !== 1'b1 || bus.freqMhz !== 1'b0) begin
      errors++; $display("[TB] FAIL single_at_fall got=%b->%b want=1->0", prevF, bus.freqMhz);
    end
    checks++;
    if (n > 12) begin errors++; $display("[TB] FAIL single_latency got=%0d want<=12", n); end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL single_ack_pulse got=ack%b/busy%b want=0/0", bus.ack0, bus.busy);
    end
    measureRuns(24, mn, mx, fr);
    checks++;
    if (mn != 2 || mx != 2 || fr < 2) begin
      errors++; $display("[TB] FAIL single_period got=min%0d/max%0d want=2/2", mn, mx);
    end
    expDiv = 1;
  endtask

  task automatic test_contention();
    int   n;
    int   mn, mx, fr;
    logic a0, a1;
    applyReset();
    bus.req0 = 1'b1;
    bus.div0 = 5'd9;
    bus.req1 = 1'b1;
    bus.div1 = 5'd24;
    waitAck(13, n, a0, a1);
    checks++;
    if (a0 !== 1'b1 || a1 !== 1'b0) begin errors++; $display("[TB] FAIL contention_first got=%b%b want=10", a0, a1); end
    checks++;
    if (bus.cur_div !== 5'd9) begin errors++; $display("[TB] FAIL contention_first_div got=%0d want=9", bus.cur_div); end
    waitAck(30, n, a0, a1);
    checks++;
    if (a0 !== 1'b0 || a1 !== 1'b1) begin errors++; $display("[TB] FAIL contention_second got=%b%b want=01", a0, a1); end
    checks++;
    if (bus.cur_div !== 5'd24 || n > 24) begin
      errors++; $display("[TB] FAIL contention_second_div got=%0d/lat%0d want=24/<=24", bus.cur_div, n);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    measureRuns(130, mn, mx, fr);
    checks++;
    if (mn != 25 || mx != 25 || fr < 2) begin
      errors++; $display("[TB] FAIL contention_period got=min%0d/max%0d want=25/25", mn, mx);
    end
    expDiv = 24;
  endtask

  task automatic test_same_value();
    int n;
    int p;
    int phaseErr;
    alignFall(60, n);
    checks++;
    if (n >= 60) begin errors++; $display("[TB] FAIL same_align got=timeout want=fall"); end
    p = 0;
    phaseErr = 0;
    for (int i = 1; i <= 120; i++) begin
      if (i == 5) begin
        bus.req1 = 1'b1;
        bus.div1 = 5'd24;
      end
      tick();
      p++;
      if (bus.freqMhz !== (((p % 50) >= 25) ? 1'b1 : 1'b0)) phaseErr++;
      if (i == 5) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.ack1 !== 1'b0) begin
          errors++; $display("[TB] FAIL same_grant got=busy%b/ack%b want=1/0", bus.busy, bus.ack1);
        end
      end
      if (i == 6) begin
        checks++;
        if (bus.ack1 !== 1'b1 || bus.ack0 !== 1'b0 || bus.cur_div !== 5'd24) begin
          errors++; $display("[TB] FAIL same_ack got=ack%b%b/div%0d want=01/24", bus.ack0, bus.ack1, bus.cur_div);
        end
        bus.req1 = 1'b0;
      end
      if (i == 7) begin
        checks++;
        if (bus.ack1 !== 1'b0) begin errors++; $display("[TB] FAIL same_ack_pulse got=%b want=0", bus.ack1); end
      end
    end
    checks++;
    if (phaseErr != 0) begin errors++; $display("[TB] FAIL same_phase got=%0d_bad_cycles want=0", phaseErr); end
  endtask

  task automatic test_disabled();
    int n;
    int mn, mx, fr;
    int highSeen;
    bus.en = 1'b0;
    tick();
    tick();
    highSeen = 0;
    bus.req0 = 1'b1;
    bus.div0 = 5'd8;
    tick();
    if (bus.freqMhz !== 1'b0) highSeen++;
    checks++;
    if (bus.busy !== 1'b1 || bus.ack0 !== 1'b0) begin
      errors++; $display("[TB] FAIL disabled_grant got=busy%b/ack%b want=1/0", bus.busy, bus.ack0);
    end
    tick();
    if (bus.freqMhz !== 1'b0) highSeen++;
    checks++;
    if (bus.ack0 !== 1'b1 || bus.cur_div !== 5'd8) begin
      errors++; $display("[TB] FAIL disabled_ack got=ack%b/div%0d want=1/8", bus.ack0, bus.cur_div);
    end
    bus.req0 = 1'b0;
    tick();
    if (bus.freqMhz !== 1'b0) highSeen++;
    checks++;
    if (bus.ack0 !== 1'b0 || highSeen != 0) begin
      errors++; $display("[TB] FAIL disabled_quiet got=ack%b/high%0d want=0/0", bus.ack0, highSeen);
    end
    bus.en = 1'b1;
    n = 0;
    while (bus.freqMhz !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (n != 9) begin errors++; $display("[TB] FAIL disabled_first_rise got=%0d want=9", n); end
    measureRuns(60, mn, mx, fr);
    checks++;
    if (mn != 9 || mx != 9 || fr < 2) begin
      errors++; $display("[TB] FAIL disabled_period got=min%0d/max%0d want=9/9", mn, mx);
    end
    expDiv = 8;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int riseAt;
    int ackSeen;
    alignFall(40, n);
    bus.req0 = 1'b1;
    bus.div0 = 5'd1;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL midwait_busy got=%b want=1", bus.busy); end
    tick();
    rst = 1'b1;
    tick();
    bus.req0 = 1'b0;
    checks++;
    if (bus.ack0 !== 1'b0 || bus.busy !== 1'b0 || bus.cur_div !== 5'd4 || bus.freqMhz !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midwait_reset got=ack%b/busy%b/div%0d/f%b want=0/0/4/0",
               bus.ack0, bus.busy, bus.cur_div, bus.freqMhz);
    end
    tick();
    rst = 1'b0;
    riseAt = -1;
    ackSeen = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.ack0 || bus.ack1) ackSeen++;
      if (riseAt < 0 && bus.freqMhz === 1'b1) riseAt = i;
    end
    checks++;
    if (ackSeen != 0 || riseAt != 5) begin
      errors++; $display("[TB] FAIL midwait_after got=acks%0d/rise%0d want=0/5", ackSeen, riseAt);
    end
    expDiv = 4;
  endtask

  task automatic test_random();
    int   oldD, newD, id, n, pad;
    int   mn, mx, fr;
    logic useEn, a0, a1;
    for (int it = 0; it < 10; it++) begin
      oldD = expDiv;
      id = $urandom_range(0, 1);
      newD = (it == 3) ? oldD : $urandom_range(0, 31);
      useEn = ($urandom_range(0, 3) != 0);
      bus.en = useEn;
      pad = $urandom_range(0, 7);
      for (int k = 0; k < pad; k++) tick();
      if (id == 1) begin bus.req1 = 1'b1; bus.div1 = 5'(newD); end
      else         begin bus.req0 = 1'b1; bus.div0 = 5'(newD); end
      tick();
      if (id == 1) bus.div1 = 5'(newD) ^ 5'h1F;
      else         bus.div0 = 5'(newD) ^ 5'h1F;
      waitAck(2 * (oldD + 1) + 3, n, a0, a1);
      n = n + 1;
      checks++;
      if (a0 !== (id == 0) || a1 !== (id == 1)) begin
        errors++; $display("[TB] FAIL rand%0d_ack_id got=%b%b want_id=%0d", it, a0, a1, id);
      end
      checks++;
      if (bus.cur_div !== 5'(newD)) begin
        errors++; $display("[TB] FAIL rand%0d_cur_div got=%0d want=%0d", it, bus.cur_div, newD);
      end
      checks++;
      if ((!useEn || newD == oldD) ? (n != 2) : (n < 2 || n > 2 * (oldD + 1) + 2)) begin
        errors++; $display("[TB] FAIL rand%0d_latency got=%0d en=%b old=%0d new=%0d", it, n, useEn, oldD, newD);
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.en = 1'b1;
      tick();
      expDiv = newD;
      measureRuns(6 * (newD + 1) + 4, mn, mx, fr);
      checks++;
      if (mn != newD + 1 || mx != newD + 1 || fr < 2) begin
        errors++; $display("[TB] FAIL rand%0d_period got=min%0d/max%0d want=%0d", it, mn, mx, newD + 1);
      end
    end
  endtask

`ifdef CLK_DIV_SCHED_LOCK_EN
  task automatic test_lock();
    int   n, activity;
    logic a0, a1;
    lock = 1'b1;
    bus.req0 = 1'b1;
    bus.div0 = (expDiv == 2) ? 5'd3 : 5'd2;
    activity = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.busy || bus.ack0 || bus.ack1) activity++;
    end
    checks++;
    if (activity != 0) begin errors++; $display("[TB] FAIL lock_hold got=%0d want=0", activity); end
    lock = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL lock_release_busy got=%b want=1", bus.busy); end
    waitAck(2 * (expDiv + 1) + 3, n, a0, a1);
    checks++;
    if (a0 !== 1'b1 || a1 !== 1'b0 || bus.cur_div !== bus.div0) begin
      errors++; $display("[TB] FAIL lock_complete got=ack%b%b/div%0d want=10/%0d", a0, a1, bus.cur_div, bus.div0);
    end
    bus.req0 = 1'b0;
    tick();
  endtask
`endif

  // Scenario sequence
  initial begin
    errors = 0;
    checks = 0;
    expDiv = 4;
    rst = 1'b1;
`ifdef CLK_DIV_SCHED_LOCK_EN
    lock = 1'b0;
`endif
    bus.en = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.div0 = '0;
    bus.div1 = '0;
    test_reset();
    test_single_change();
    test_contention();
    test_same_value();
    test_disabled();
    test_reset_mid_wait();
    test_random();
`ifdef CLK_DIV_SCHED_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
